// File: rtl/bcd_updown_display_pkg.sv
// Shared types and helpers for the BCD up/down counter display: count direction
// and the active-low 7-segment encoder.
package bcd_disp_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Segment order {a,b,c,d,e,f,g,dp}; 0 = lit; dp always off.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'b00000011;
            4'd1:    code = 8'b10011111;
            4'd2:    code = 8'b00100101;
            4'd3:    code = 8'b00001101;
            4'd4:    code = 8'b10011001;
            4'd5:    code = 8'b01001001;
            4'd6:    code = 8'b01000001;
            4'd7:    code = 8'b00011111;
            4'd8:    code = 8'b00000001;
            4'd9:    code = 8'b00001001;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_updown_display_if.sv
// Control and display bundle of the BCD up/down counter. The controller (master)
// drives en/updown/load/load_val; the counter (slave) drives count and display.
interface bcd_updown_display_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  updown;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  wrap;
    logic                  load_err;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, updown, load, load_val,
        input  count_bcd, wrap, load_err, seg, an
    );

    modport slave (
        input  en, updown, load, load_val,
        output count_bcd, wrap, load_err, seg, an
    );
endinterface

// File: rtl/bcd_updown_display_digit.sv
// One BCD decade. Steps when i_en_in is high (all lower decades at their limit),
// load wins over stepping; o_at_limit flags 9 counting up or 0 counting down.
module bcd_digit
    import bcd_disp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en_in,
    input  logic       i_updown,
    input  logic       i_load,
    input  logic [3:0] i_load_nib,
    output logic [3:0] o_digit,
    output logic       o_at_limit
);
    logic [3:0] r_digit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            // Out-of-range nibbles load as zero; the top level reports the error.
            r_digit <= (i_load_nib > BCD_MAX) ? 4'd0 : i_load_nib;
        end else if (i_en_in) begin
            if (i_updown == DIR_DOWN) begin
                r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
            end else begin
                r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
            end
        end
    end

    assign o_digit    = r_digit;
    assign o_at_limit = (i_updown == DIR_DOWN) ? (r_digit == 4'd0) : (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with load, wrap pulse, load error pulse and a
// time-multiplexed 7-segment driver with optional leading-zero blanking.
module bcd_updown_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int SCAN_DIV       = 16,
    parameter int BLANK_LZ       = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    bcd_updown_display_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]        SEG_RST = (SEG_ACTIVE_LOW != 0) ? seg_encode(4'd0) : ~seg_encode(4'd0);
    localparam logic [DIGITS-1:0] AN_RST  = (SEG_ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

    logic [4*DIGITS-1:0] w_count;
    logic [DIGITS:0]     w_chain;
    logic [DIGITS-1:0]   w_lim;
    logic [DIGITS-1:0]   w_bad_nib;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [7:0]          w_seg_lo;
    logic [DIGITS-1:0]   w_an_lo;

    logic                r_wrap;
    logic                r_load_err;
    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    // w_chain[k] is the step enable of decade k: en and every lower decade at limit.
    assign w_chain[0] = bus.en;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .i_en_in    (w_chain[k]),
            .i_updown   (bus.updown),
            .i_load     (bus.load),
            .i_load_nib (bus.load_val[4*k +: 4]),
            .o_digit    (w_count[4*k +: 4]),
            .o_at_limit (w_lim[k])
        );
        assign w_chain[k+1] = w_chain[k] & w_lim[k];
        assign w_bad_nib[k] = (bus.load_val[4*k +: 4] > BCD_MAX);

        // w_lz[k]: decade k and every higher decade are zero.
        if (k == DIGITS - 1) begin : g_lz_top
            assign w_lz[k] = (w_count[4*k +: 4] == 4'd0);
        end else begin : g_lz_mid
            assign w_lz[k] = w_lz[k+1] & (w_count[4*k +: 4] == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= ~bus.load & w_chain[DIGITS];
            r_load_err <= bus.load & (|w_bad_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        w_an_lo = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit    = w_count[4*k +: 4];
                w_blank    = (BLANK_LZ != 0) && (k > 0) && w_lz[k];
                w_an_lo[k] = 1'b0;
            end
        end
        w_seg_lo = w_blank ? SEG_BLANK : seg_encode(w_digit);
    end

    // seg and an share one register stage so the digit select and its pattern switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= SEG_RST;
            r_an  <= AN_RST;
        end else begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? w_seg_lo : ~w_seg_lo;
            r_an  <= (SEG_ACTIVE_LOW != 0) ? w_an_lo  : ~w_an_lo;
        end
    end

    assign bus.count_bcd = w_count;
    assign bus.wrap      = r_wrap;
    assign bus.load_err  = r_load_err;
    assign bus.seg       = r_seg;
    assign bus.an        = r_an;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Bench for bcd_updown_display: two instances (plain active-low, and blanking
// with active-high outputs) driven identically and checked against an integer model.
module tb_bcd_updown_display;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MOD      = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_updown_display_if #(.DIGITS(DIGITS)) bus_a ();
    bcd_updown_display_if #(.DIGITS(DIGITS)) bus_b ();

    assign bus_b.en       = bus_a.en;
    assign bus_b.updown   = bus_a.updown;
    assign bus_b.load     = bus_a.load;
    assign bus_b.load_val = bus_a.load_val;

    bcd_updown_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0), .SEG_ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    bcd_updown_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    logic [7:0] seg_tab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                 8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                 8'b00000001, 8'b00001001};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count as a plain integer, scan position from cycles since reset.
    int          m_val = 0;
    int          m_cyc = 0;
    bit          m_wrap = 1'b0;
    bit          m_lerr = 1'b0;
    logic [7:0]  m_seg_a, m_seg_b;
    logic [DIGITS-1:0] m_an_a, m_an_b;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    task automatic set_disp(input int val, input int idx);
        int  d;
        bit  blank;
        d       = (val / pow10(idx)) % 10;
        blank   = (idx > 0) && (val / pow10(idx) == 0);
        m_seg_a = seg_tab[d];
        m_seg_b = blank ? 8'h00 : ~seg_tab[d];
        m_an_a  = ~(DIGITS'(1) << idx);
        m_an_b  = DIGITS'(1) << idx;
    endtask

    task automatic tick(input bit rst, input bit ld, input logic [W-1:0] lv, input bit e, input bit ud);
        int  v, nib;
        bit  bad;
        reset        = rst;
        bus_a.load   = ld;
        bus_a.load_val = lv;
        bus_a.en     = e;
        bus_a.updown = ud;
        @(posedge clk);
        if (rst) begin
            m_val = 0; m_cyc = 0; m_wrap = 1'b0; m_lerr = 1'b0;
            set_disp(0, 0);
        end else begin
            set_disp(m_val, (m_cyc / SCAN_DIV) % DIGITS);
            m_cyc++;
            m_wrap = 1'b0;
            m_lerr = 1'b0;
            if (ld) begin
                v = 0; bad = 1'b0;
                for (int k = 0; k < DIGITS; k++) begin
                    nib = int'(lv[4*k +: 4]);
                    if (nib > 9) bad = 1'b1;
                    else v += nib * pow10(k);
                end
                m_val  = v;
                m_lerr = bad;
            end else if (e) begin
                if (!ud) begin
                    m_wrap = (m_val == MOD - 1);
                    m_val  = (m_val + 1) % MOD;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val + MOD - 1) % MOD;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 8'h47, 1'b0, 1'b0);
        n_vec++;
        if (bus_a.count_bcd !== 8'h47) begin n_err++; $display("FAIL reset_preload count got %h exp 47", bus_a.count_bcd); end
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        n_vec += 6;
        if (bus_a.count_bcd !== 8'h00)       begin n_err++; $display("FAIL reset count got %h exp 00", bus_a.count_bcd); end
        if (bus_a.wrap !== 1'b0)             begin n_err++; $display("FAIL reset wrap got %b exp 0", bus_a.wrap); end
        if (bus_a.load_err !== 1'b0)         begin n_err++; $display("FAIL reset load_err got %b exp 0", bus_a.load_err); end
        if (bus_a.an !== 2'b10)              begin n_err++; $display("FAIL reset an got %b exp 10", bus_a.an); end
        if (bus_a.seg !== 8'b00000011)       begin n_err++; $display("FAIL reset seg got %b exp 00000011", bus_a.seg); end
        if (bus_b.seg !== 8'b11111100 || bus_b.an !== 2'b01) begin
            n_err++; $display("FAIL reset_inv seg/an got %b/%b exp 11111100/01", bus_b.seg, bus_b.an);
        end
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] exp_c [3] = '{8'h99, 8'h00, 8'h01};
        bit           exp_w [3] = '{1'b0, 1'b1, 1'b0};
        tick(1'b0, 1'b1, 8'h98, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_vec += 2;
            if (bus_a.count_bcd !== exp_c[i]) begin n_err++; $display("FAIL up_wrap count[%0d] got %h exp %h", i, bus_a.count_bcd, exp_c[i]); end
            if (bus_a.wrap !== exp_w[i])      begin n_err++; $display("FAIL up_wrap wrap[%0d] got %b exp %b", i, bus_a.wrap, exp_w[i]); end
        end
    endtask

    task automatic test_down_wrap();
        logic [W-1:0] exp_c [3] = '{8'h00, 8'h99, 8'h98};
        bit           exp_w [3] = '{1'b0, 1'b1, 1'b0};
        tick(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n_vec += 2;
            if (bus_a.count_bcd !== exp_c[i]) begin n_err++; $display("FAIL down_wrap count[%0d] got %h exp %h", i, bus_a.count_bcd, exp_c[i]); end
            if (bus_a.wrap !== exp_w[i])      begin n_err++; $display("FAIL down_wrap wrap[%0d] got %b exp %b", i, bus_a.wrap, exp_w[i]); end
        end
    endtask

    task automatic test_load_err();
        tick(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        n_vec += 2;
        if (bus_a.count_bcd !== 8'h30) begin n_err++; $display("FAIL load_err count got %h exp 30", bus_a.count_bcd); end
        if (bus_a.load_err !== 1'b1)   begin n_err++; $display("FAIL load_err pulse got %b exp 1", bus_a.load_err); end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_vec += 2;
        if (bus_a.load_err !== 1'b0)   begin n_err++; $display("FAIL load_err clear got %b exp 0", bus_a.load_err); end
        if (bus_a.count_bcd !== 8'h30) begin n_err++; $display("FAIL load_err hold got %h exp 30", bus_a.count_bcd); end
        tick(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
        n_vec += 3;
        if (bus_a.count_bcd !== 8'h99) begin n_err++; $display("FAIL load_prio count got %h exp 99", bus_a.count_bcd); end
        if (bus_a.wrap !== 1'b0)       begin n_err++; $display("FAIL load_prio wrap got %b exp 0", bus_a.wrap); end
        if (bus_a.load_err !== 1'b0)   begin n_err++; $display("FAIL load_prio load_err got %b exp 0", bus_a.load_err); end
    endtask

    task automatic test_scan();
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'h25, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            n_vec += 4;
            if (bus_a.an !== m_an_a)   begin n_err++; $display("FAIL scan an_a[%0d] got %b exp %b", i, bus_a.an, m_an_a); end
            if (bus_a.seg !== m_seg_a) begin n_err++; $display("FAIL scan seg_a[%0d] got %b exp %b", i, bus_a.seg, m_seg_a); end
            if (bus_b.an !== m_an_b)   begin n_err++; $display("FAIL scan an_b[%0d] got %b exp %b", i, bus_b.an, m_an_b); end
            if (bus_b.seg !== m_seg_b) begin n_err++; $display("FAIL scan seg_b[%0d] got %b exp %b", i, bus_b.seg, m_seg_b); end
        end
    endtask

    task automatic test_blank();
        logic [W-1:0] vals [2] = '{8'h07, 8'h00};
        for (int v = 0; v < 2; v++) begin
            tick(1'b0, 1'b1, vals[v], 1'b0, 1'b0);
            for (int i = 0; i < 2 * SCAN_DIV + 1; i++) begin
                tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
                n_vec += 2;
                if (bus_b.seg !== m_seg_b) begin n_err++; $display("FAIL blank seg_b[%0d.%0d] got %b exp %b", v, i, bus_b.seg, m_seg_b); end
                if (bus_a.seg !== m_seg_a) begin n_err++; $display("FAIL noblank seg_a[%0d.%0d] got %b exp %b", v, i, bus_a.seg, m_seg_a); end
            end
        end
    endtask

    task automatic test_random();
        bit            rst, ld, e, ud;
        logic [W-1:0]  lv;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            e   = ($urandom_range(0, 3) != 0);
            ud  = $urandom_range(0, 1) == 1;
            lv  = W'($urandom);
            tick(rst, ld, lv, e, ud);
            n_vec += 7;
            if (bus_a.count_bcd !== to_bcd(m_val)) begin n_err++; $display("FAIL rnd count[%0d] got %h exp %h", i, bus_a.count_bcd, to_bcd(m_val)); end
            if (bus_b.count_bcd !== to_bcd(m_val)) begin n_err++; $display("FAIL rnd count_b[%0d] got %h exp %h", i, bus_b.count_bcd, to_bcd(m_val)); end
            if (bus_a.wrap !== m_wrap)             begin n_err++; $display("FAIL rnd wrap[%0d] got %b exp %b", i, bus_a.wrap, m_wrap); end
            if (bus_a.load_err !== m_lerr)         begin n_err++; $display("FAIL rnd load_err[%0d] got %b exp %b", i, bus_a.load_err, m_lerr); end
            if (bus_a.seg !== m_seg_a || bus_a.an !== m_an_a) begin
                n_err++; $display("FAIL rnd disp_a[%0d] got %b/%b exp %b/%b", i, bus_a.seg, bus_a.an, m_seg_a, m_an_a);
            end
            if (bus_b.seg !== m_seg_b)             begin n_err++; $display("FAIL rnd seg_b[%0d] got %b exp %b", i, bus_b.seg, m_seg_b); end
            if (bus_b.an !== m_an_b)               begin n_err++; $display("FAIL rnd an_b[%0d] got %b exp %b", i, bus_b.an, m_an_b); end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus_a.en       = 1'b0;
        bus_a.updown   = 1'b0;
        bus_a.load     = 1'b0;
        bus_a.load_val = '0;
        @(negedge clk);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_err();
        test_scan();
        test_blank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_updown_display.md
Name: bcd_updown_display

Overview:
Parametrised N-digit BCD up/down counter with a multiplexed 7-segment display driver. It generalises the 2-digit 0..99 counter to DIGITS decades, with the following additions:
- count enable and synchronous parallel load
- wrap pulse
- optional leading-zero blanking
- time-multiplexed anode scan

It sits between board controls/timebase and the 7-seg connector on the Spartan-6 board.

Parameters:
DIGITS, 2, number of BCD decades (1..8); count range 0..10^DIGITS-1
SCAN_DIV, 16, clk cycles each digit is displayed before the scan advances (>=2)
BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 never blanked)
SEG_ACTIVE_LOW, 1, 1 = seg/an active-low; 0 = both inverted (active-high)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  count enable, one step per cycle while high
updown  in  1  0 = count up, 1 = count down
load  in  1  synchronous parallel load strobe
load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
count_bcd  out  4*DIGITS  current count, BCD, registered
wrap  out  1  one-cycle pulse on wrap-around
load_err  out  1  one-cycle pulse when load_val held a nibble >9
seg  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a; registered
an  out  DIGITS  digit select, one-hot (active level per SEG_ACTIVE_LOW); registered

Behaviour:
- Reset is synchronous, active-high, sampled on the clk rising edge. On reset:
  - count_bcd = 0, wrap = 0, load_err = 0
  - scan divider = 0, digit index = 0
  - an selects digit 0; seg = code for "0" (8'b00000011 when active-low)
- Counter priority, evaluated each edge: reset > load > en. No change when none is active.
- load:
  - Each nibble of load_val that is <=9 is loaded as-is.
  - Any nibble >9 is loaded as 0 and load_err pulses for the next cycle.
  - wrap = 0 on a load cycle.
- en & up:
  - Each decade increments only when all lower decades equal 9 (BCD ripple); 9 -> 0 within a decade.
  - At all-9s the count goes to all-0s and wrap pulses.
- en & down:
  - Each decade decrements only when all lower decades equal 0; 0 -> 9 within a decade.
  - At all-0s the count goes to all-9s and wrap pulses.
- Counter latency: count_bcd reflects a step one cycle after en is sampled. wrap is asserted in the same cycle the wrapped value appears.
- updown may change on any cycle; it takes effect on the next enabled step. No pipeline state.
- Scan:
  - The divider counts 0..SCAN_DIV-1.
  - On its terminal value the digit index advances to idx+1, wrapping DIGITS-1 -> 0.
  - The divider runs regardless of en/load.
- Display:
  - seg and an at cycle t+1 reflect the count_bcd and digit index at cycle t.
  - seg and an are always updated together, so there is no ghosting glitch.
- Segment codes (active-low, dp always off = 1):
  - 0 = 00000011, 1 = 10011111, 2 = 00100101, 3 = 00001101, 4 = 10011001
  - 5 = 01001001, 6 = 01000001, 7 = 00011111, 8 = 00000001, 9 = 00001001
  - blank = 11111111
- BLANK_LZ = 1: a digit k > 0 is blanked when it and every higher digit equal 0.
- SEG_ACTIVE_LOW = 0: seg and an are the bitwise inverse of the active-low values.
- DIGITS = 1: an is constant-active and the scan index stays 0.

Decomposition:
- Package bcd_disp_pkg:
  - function seg_encode(4-bit digit) -> 8-bit active-low code
  - constants SEG_BLANK = 8'hFF, BCD_MAX = 4'd9
- Sub-module bcd_digit, instantiated DIGITS times:
  - one decade with en_in (all-lower-at-limit), updown, load, load nibble
  - outputs: digit value and at_limit (9 when up, 0 when down)
- The top level chains at_limit, detects wrap, and holds the scan divider and output registers.

Test Plan:
All scenarios use DIGITS=2, SCAN_DIV=4 unless stated otherwise.
- Reset mid-count at 47 -> next cycle count_bcd = 8'h00, wrap = 0, an = 2'b10, seg = 00000011 after one cycle.
- Load 8'h98, up, en for 3 cycles -> 99, 00 with wrap high on the 00 cycle only, then 01.
- Load 8'h01, down, en for 3 cycles -> 00, 99 with wrap pulse, then 98.
- Load 8'h3C -> count_bcd = 8'h30, load_err pulses for one cycle; load and en together -> load wins.
- Count = 8'h25, observe 16 cycles -> an alternates every 4 cycles 10/01/10/01; seg = 01001001 (digit 0 = 5) while an = 10 and 00100101 (digit 1 = 2) while an = 01, each delayed one cycle.
- BLANK_LZ=1, count = 8'h07 -> digit 1 shows 11111111, digit 0 shows 00011111; count 8'h00 -> digit 0 shows 00000011.
